// File: rtl/icache_line_filler.sv
// icache_line_filler: fetches demand-miss lines into the icache arrays and, when
// ICACHE_NEXT_LINE_PREFETCH_EN is defined, prefetches the next sequential line.
module icache_line_filler #(
   parameter int  s_index  = 3,
   parameter int  s_offset = 5,
   parameter int  s_line   = 256,
   localparam int s_tag    = 32 - s_index - s_offset
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               miss_req_i,
   input  logic [31:0]        miss_addr_i,
   output logic               miss_ready_o,
   output logic               fill_done_o,
   output logic               pmem_read_o,
   output logic [31:0]        pmem_address_o,
   input  logic               pmem_resp_i,
   input  logic [s_line-1:0]  pmem_rdata_i,
   output logic               load_o,
   output logic [s_index-1:0] windex_o,
   output logic [s_tag-1:0]   fill_tag_o,
   output logic [s_line-1:0]  fill_line_o,
   output logic [s_index-1:0] next_set_o,
   input  logic               next_valid_i,
   input  logic [s_tag-1:0]   next_tag_i,
   output logic               next_load_o,
   output logic [s_index-1:0] pref_set_o,
   output logic [s_tag-1:0]   pref_tag_o,
   output logic [s_line-1:0]  pref_line_o
);

   typedef enum logic [2:0] {
      IDLE,
      DREQ,
      DWRITE,
      PCHECK,
      PREQ,
      PWRITE
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       line_addr_q, line_addr_d;
   logic [s_line-1:0] data_q, data_d;
   logic [31:0]       miss_line;

   // Offset bits of the miss address never matter; the line is always aligned.
   logic unused_offset_bits;
   assign unused_offset_bits = ^miss_addr_i[s_offset-1:0];
   assign miss_line = {miss_addr_i[31:s_offset], {s_offset{1'b0}}};

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
   logic [31:0]      pf_addr_q, pf_addr_d;
   logic [s_tag-1:0] pf_tag;

   // Next-line address wraps modulo 2^32, so the top line prefetches line 0.
   assign pf_addr_d = (state_q == IDLE && miss_req_i) ? (miss_line + (32'd1 << s_offset)) : pf_addr_q;
   assign pf_tag    = pf_addr_q[31 -: s_tag];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pf_addr_q <= '0;
      end else begin
         pf_addr_q <= pf_addr_d;
      end
   end

   assign next_set_o  = pf_addr_q[s_offset +: s_index];
   assign pref_set_o  = pf_addr_q[s_offset +: s_index];
   assign pref_tag_o  = pf_tag;
   assign pref_line_o = data_q;
`else
   logic unused_probe_inputs;
   assign unused_probe_inputs = ^{next_valid_i, next_tag_i};

   assign next_set_o  = '0;
   assign pref_set_o  = '0;
   assign pref_tag_o  = '0;
   assign pref_line_o = '0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         line_addr_q <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         line_addr_q <= line_addr_d;
         data_q      <= data_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      line_addr_d    = line_addr_q;
      data_d         = data_q;
      miss_ready_o   = 1'b0;
      fill_done_o    = 1'b0;
      pmem_read_o    = 1'b0;
      pmem_address_o = '0;
      load_o         = 1'b0;
      next_load_o    = 1'b0;

      unique case (state_q)
         IDLE: begin
            miss_ready_o = 1'b1;
            if (miss_req_i) begin
               line_addr_d = miss_line;
               state_d     = DREQ;
            end
         end
         DREQ: begin
            pmem_read_o    = 1'b1;
            pmem_address_o = line_addr_q;
            if (pmem_resp_i) begin
               data_d  = pmem_rdata_i;
               state_d = DWRITE;
            end
         end
         DWRITE: begin
            load_o      = 1'b1;
            fill_done_o = 1'b1;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
            state_d     = PCHECK;
`else
            state_d     = IDLE;
`endif
         end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
         // A resident next line is left alone; no memory request is issued.
         PCHECK: begin
            if (next_valid_i && (next_tag_i == pf_tag)) begin
               state_d = IDLE;
            end else begin
               state_d = PREQ;
            end
         end
         PREQ: begin
            pmem_read_o    = 1'b1;
            pmem_address_o = pf_addr_q;
            if (pmem_resp_i) begin
               data_d  = pmem_rdata_i;
               state_d = PWRITE;
            end
         end
         PWRITE: begin
            next_load_o = 1'b1;
            state_d     = IDLE;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign windex_o    = line_addr_q[s_offset +: s_index];
   assign fill_tag_o  = line_addr_q[31 -: s_tag];
   assign fill_line_o = data_q;

endmodule
